// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK], trapping on illegal opcodes or memory timeouts.
// Optional macro PERF_COUNTER_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl_fsm #(
    parameter int MAX_WAIT = 255,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        opcode,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    input  logic              branch_taken,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              alu_src_imm,
    output logic [1:0]        alu_op,
    output logic              ALU_En,
    output logic              halted,
    output logic              bus_error,
    output logic              illegal_instr,
`ifdef PERF_COUNTER_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R     = 3'd0,
        C_I     = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_BR    = 3'd4
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
    logic       illegal_q, illegal_d;
    logic       op_legal;
    cls_t       op_cls;

    function automatic logic [1:0] cls_alu_op(input cls_t c);
        logic [1:0] op;
        case (c)
            C_R:             op = 2'b00;
            C_I:             op = 2'b01;
            C_LOAD, C_STORE: op = 2'b10;
            C_BR:            op = 2'b11;
            default:         op = 2'b00;
        endcase
        return op;
    endfunction

    always_comb begin
        op_legal = 1'b1;
        op_cls   = C_R;
        case (opcode)
            7'b0110011: op_cls = C_R;
            7'b0010011: op_cls = C_I;
            7'b0000011: op_cls = C_LOAD;
            7'b0100011: op_cls = C_STORE;
            7'b1100011: op_cls = C_BR;
            default:    op_legal = 1'b0;
        endcase
    end

    // The wait counter only survives while a request waits; every other path clears it.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = 8'd0;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    cls_d   = op_cls;
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BR:            state_d = S_FETCH;
                    default:         state_d = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 2'b00;
        ALU_En      = 1'b1;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXECUTE: begin
                ALU_En      = 1'b0;
                alu_op      = cls_alu_op(cls_q);
                alu_src_imm = (cls_q == C_I) || (cls_q == C_LOAD) || (cls_q == C_STORE);
                if (cls_q == C_BR) begin
                    pc_src   = 1'b1;
                    pc_write = branch_taken;
                end
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (cls_q == C_STORE);
                ALU_En      = 1'b0;
                alu_op      = 2'b10;
                alu_src_imm = 1'b1;
            end
            S_WRITEBACK: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign halted        = (state_q == S_TRAP);
    assign bus_error     = bus_err_q;
    assign illegal_instr = illegal_q;
    assign dbg_state     = state_q;

`ifdef PERF_COUNTER_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] cycle_q, instret_q;
    logic              retire;

    // An instruction retires when its last step hands control back to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXECUTE) || (state_q == S_MEM) || (state_q == S_WRITEBACK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_TRAP)) cycle_q <= cycle_q + PERF_ONE;
            if (retire) instret_q <= instret_q + PERF_ONE;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

    a_param_range: assert property (@(posedge clk)
        (MAX_WAIT >= 1) && (MAX_WAIT <= 255) && (PERF_W >= 1));

    a_one_request: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_req && dmem_req));

    a_trap_quiet: assert property (@(posedge clk) disable iff (!reset_n)
        halted |-> !(imem_req || dmem_req || dmem_we || ir_write || pc_write || reg_write));

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: step-queue reference model compared every cycle,
// plus directed literal checks; PERF_COUNTER_EN also enables the counter checks.
module tb_multicycle_ctrl_fsm;

  localparam int TB_MAX_WAIT = 4;
  localparam int W = 14;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Step kinds of the reference model's per-instruction plan
  localparam int K_IDLE = 0, K_FETCH = 1, K_DEC = 2, K_EXE = 3, K_MEM = 4, K_WB = 5;

  // Bit positions inside the packed output vector
  localparam int B_ILL = 0, B_BUS = 1, B_HALT = 2, B_EN = 3, B_OP = 4, B_IMM = 6, B_RW = 7;
  localparam int B_PCSRC = 8, B_PCW = 9, B_IRW = 10, B_WE = 11, B_DREQ = 12, B_IREQ = 13;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = OP_R;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       branch_taken = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic       reg_write, alu_src_imm, ALU_En, halted, bus_error, illegal_instr;
  logic [1:0] alu_op;
  logic [2:0] dbg_state;
`ifdef PERF_COUNTER_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           steps[$];
  int           m_wait = 0;
  bit           m_trap = 1'b0;
  bit           m_bus = 1'b0;
  bit           m_ill = 1'b0;
  logic [6:0]   m_op = 7'd0;
  logic [31:0]  m_cyc = 32'd0;
  logic [31:0]  m_ret = 32'd0;

  multicycle_ctrl_fsm #(.MAX_WAIT(TB_MAX_WAIT), .PERF_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .ALU_En(ALU_En), .halted(halted), .bus_error(bus_error), .illegal_instr(illegal_instr),
`ifdef PERF_COUNTER_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
  endfunction

  function automatic logic [1:0] op_class(input logic [6:0] op);
    if (op == OP_R) return 2'd0;
    if (op == OP_I) return 2'd1;
    if (op == OP_BR) return 2'd3;
    return 2'd2;
  endfunction

  function automatic logic [6:0] rand_op();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 7'($urandom_range(0, 127));
    case (r % 5)
      0: return OP_R;
      1: return OP_I;
      2: return OP_LD;
      3: return OP_ST;
      default: return OP_BR;
    endcase
  endfunction

  // ---------------- reference model + compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    int cur;
    bit fin;
    e = '0;
    e[B_EN] = 1'b1;
    if (!reset_n) begin
      steps.delete();
      steps.push_back(K_IDLE);
      m_wait = 0; m_trap = 0; m_bus = 0; m_ill = 0;
      m_cyc = 32'd0; m_ret = 32'd0;
`ifdef PERF_COUNTER_EN
      check("cycle_cnt_rst", cycle_cnt, 32'd0);
      check("instret_cnt_rst", instret_cnt, 32'd0);
`endif
    end else if (m_trap) begin
      e[B_HALT] = 1'b1;
      e[B_BUS] = m_bus;
      e[B_ILL] = m_ill;
`ifdef PERF_COUNTER_EN
      check("cycle_cnt_trap", cycle_cnt, m_cyc);
      check("instret_cnt_trap", instret_cnt, m_ret);
`endif
    end else begin
`ifdef PERF_COUNTER_EN
      check("cycle_cnt", cycle_cnt, m_cyc);
      check("instret_cnt", instret_cnt, m_ret);
`endif
      cur = steps[0];
      fin = 1'b0;
      case (cur)
        K_IDLE: begin
          void'(steps.pop_front());
          steps.push_back(K_FETCH);
          m_wait = 0;
        end
        K_FETCH: begin
          e[B_IREQ] = 1'b1;
          if (imem_ack) begin
            e[B_IRW] = 1'b1;
            e[B_PCW] = 1'b1;
            void'(steps.pop_front());
            steps.push_back(K_DEC);
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == TB_MAX_WAIT) begin m_trap = 1; m_bus = 1; end
          end
        end
        K_DEC: begin
          void'(steps.pop_front());
          m_op = opcode;
          if (!is_legal(opcode)) begin
            m_trap = 1; m_ill = 1;
          end else if (opcode == OP_R || opcode == OP_I) begin
            steps.push_back(K_EXE); steps.push_back(K_WB);
          end else if (opcode == OP_LD) begin
            steps.push_back(K_EXE); steps.push_back(K_MEM); steps.push_back(K_WB);
          end else if (opcode == OP_ST) begin
            steps.push_back(K_EXE); steps.push_back(K_MEM);
          end else begin
            steps.push_back(K_EXE);
          end
        end
        K_EXE: begin
          e[B_EN] = 1'b0;
          e[B_OP +: 2] = op_class(m_op);
          e[B_IMM] = (m_op == OP_I) || (m_op == OP_LD) || (m_op == OP_ST);
          if (m_op == OP_BR) begin
            e[B_PCSRC] = 1'b1;
            e[B_PCW] = branch_taken;
          end
          void'(steps.pop_front());
          fin = 1'b1;
          m_wait = 0;
        end
        K_MEM: begin
          e[B_DREQ] = 1'b1;
          e[B_WE] = (m_op == OP_ST);
          e[B_EN] = 1'b0;
          e[B_OP +: 2] = 2'b10;
          e[B_IMM] = 1'b1;
          if (dmem_ack) begin
            void'(steps.pop_front());
            fin = 1'b1;
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == TB_MAX_WAIT) begin m_trap = 1; m_bus = 1; end
          end
        end
        default: begin
          e[B_RW] = 1'b1;
          void'(steps.pop_front());
          fin = 1'b1;
        end
      endcase
      if (fin && steps.size() == 0) begin
        steps.push_back(K_FETCH);
        m_ret = m_ret + 32'd1;
      end
      if (cur != K_IDLE) m_cyc = m_cyc + 32'd1;
    end
    exp_q.push_back(e);
    got = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
           alu_src_imm, alu_op, ALU_En, halted, bus_error, illegal_instr};
    check("outputs", 32'(got), 32'(exp_q.pop_front()));
  end

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic start(input logic ia, input logic da, input logic bt, input logic [6:0] op, input int n);
    adv();
    imem_ack = ia; dmem_ack = da; branch_taken = bt; opcode = op;
    reset_n = 1'b0;
    repeat (n) adv();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int hcnt;
    int pct;
    logic rw_seen;

    // R-type, zero-wait: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH
    start(1, 1, 0, OP_R, 2);
    sample(); check("r_idle_ireq", imem_req, 0); check("r_idle_alu_en", ALU_En, 1);
    sample(); check("r_fetch_ireq", imem_req, 1); check("r_fetch_irw", ir_write, 1);
    check("r_fetch_pcw", pc_write, 1);
    sample(); check("r_dec_ireq", imem_req, 0);
    sample(); check("r_exe_alu_en", ALU_En, 0); check("r_exe_alu_op", alu_op, 0);
    sample(); check("r_wb_regw", reg_write, 1);
    sample(); check("r_fetch2_ireq", imem_req, 1);

    // LOAD with dmem_ack on the 4th MEM cycle (wait-limit boundary, ack wins)
    start(1, 0, 0, OP_LD, 1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      sample();
      if (dmem_req) begin
        cnt++;
        check("ld_we", dmem_we, 0);
        check("ld_alu_op", alu_op, 2);
      end
      if (i == 8) check("ld_wb_regw", reg_write, 1);
      adv();
      dmem_ack = (cnt == 3);
    end
    check("ld_req_cycles", cnt, 4);
    check("ld_no_trap", halted, 0);

    // STORE, zero-wait: 4 cycles FETCH to FETCH, no reg_write
    start(1, 1, 0, OP_ST, 1);
    rw_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      rw_seen |= reg_write;
      if (i == 3) check("st_exe_imm", alu_src_imm, 1);
      if (i == 4) begin check("st_mem_we", dmem_we, 1); check("st_mem_req", dmem_req, 1); end
      if (i == 5) check("st_fetch_ireq", imem_req, 1);
    end
    check("st_no_regw", rw_seen, 0);

    // Branch taken / not taken
    for (int t = 0; t < 2; t++) begin
      start(1, 1, (t == 0), OP_BR, 1);
      repeat (4) sample();
      check("br_pcw", pc_write, (t == 0) ? 1 : 0);
      check("br_pcsrc", pc_src, 1);
      check("br_alu_op", alu_op, 3);
      sample(); check("br_back_fetch", imem_req, 1);
    end

    // Illegal opcode traps and holds despite acks; reset clears it
    start(1, 1, 0, 7'b1111111, 1);
    repeat (4) sample();
    check("ill_halted", halted, 1); check("ill_flag", illegal_instr, 1); check("ill_bus", bus_error, 0);
    repeat (20) sample();
    check("ill_hold_halted", halted, 1); check("ill_hold_ireq", imem_req, 0);
    check("ill_hold_flag", illegal_instr, 1);
    start(1, 1, 0, OP_R, 1);
    sample();
    check("ill_rst_halted", halted, 0); check("ill_rst_flag", illegal_instr, 0);
    check("ill_rst_alu_en", ALU_En, 1);

    // imem_ack never arrives: trap after MAX_WAIT request cycles
    start(0, 1, 0, OP_R, 1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      sample();
      if (imem_req) cnt++;
    end
    check("to_req_cycles", cnt, TB_MAX_WAIT);
    check("to_halted", halted, 1); check("to_bus", bus_error, 1); check("to_ill", illegal_instr, 0);

    // imem_ack on the last allowed cycle: normal decode
    start(0, 1, 0, OP_R, 1);
    repeat (4) sample();
    adv(); imem_ack = 1'b1;
    sample(); check("to4_irw", ir_write, 1);
    adv(); imem_ack = 1'b0;
    sample(); check("to4_no_trap", halted, 0);
    sample(); check("to4_exe_alu_en", ALU_En, 0);

    // Asynchronous reset mid-MEM drops the request immediately
    start(1, 0, 0, OP_LD, 1);
    repeat (5) sample();
    check("amem_req_before", dmem_req, 1);
    #2; reset_n = 1'b0;
    #1;
    check("amem_req_after", dmem_req, 0); check("amem_alu_en", ALU_En, 1);
    check("amem_imm", alu_src_imm, 0);
    repeat (2) adv();
    reset_n = 1'b1;

`ifdef PERF_COUNTER_EN
    // Three R-type instructions retire in 12 active cycles
    start(1, 1, 0, OP_R, 1);
    sample(); check("perf_cyc0", cycle_cnt, 0); check("perf_ret0", instret_cnt, 0);
    repeat (13) sample();
    check("perf_ret3", instret_cnt, 3); check("perf_cyc12", cycle_cnt, 12);
`endif

    // Randomized segments checked by the reference model every cycle
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 2))
        0: pct = 100;
        1: pct = 70;
        default: pct = 40;
      endcase
      start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_op(), $urandom_range(1, 3));
      hcnt = 0;
      for (int c = 0; c < 80 && hcnt < 6; c++) begin
        imem_ack = ($urandom_range(1, 100) <= pct);
        dmem_ack = ($urandom_range(1, 100) <= pct);
        branch_taken = 1'($urandom_range(0, 1));
        opcode = rand_op();
        adv();
        if (m_trap) hcnt++;
      end
    end

    adv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main multi-cycle control sequencer for the 32-bit core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit alu_op class and active-low ALU_En consumed by the ALU control decoder.
- Handshakes instruction and data memory, and traps on illegal opcodes or memory timeouts.

Parameters:
- MAX_WAIT, 255, cycles a memory request may wait for ack before trap (1..255).
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0], from the instruction register.
- imem_ack  in  1  instruction memory ack.
- dmem_ack  in  1  data memory ack.
- branch_taken  in  1  branch condition from the comparator.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (store).
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write.
- alu_src_imm  out  1  ALU operand B = immediate.
- alu_op  out  2  00 R-type, 01 I-ALU, 10 load/store, 11 branch.
- ALU_En  out  1  active-low ALU control enable.
- halted  out  1  in TRAP.
- bus_error  out  1  trap cause was a memory timeout.
- illegal_instr  out  1  trap cause was an illegal opcode.

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low. On assertion, at any time including mid-transaction:
  - state = IDLE, wait counter = 0, class register = 0.
  - All outputs 0, except ALU_En = 1.
  - An in-flight request is simply dropped.
- Outputs are combinational from the registered state and class; in FETCH/MEM they may also depend on ack. Defaults: 0, except ALU_En = 1.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req = 1, held until imem_ack. Ack on the same cycle req rises is accepted; ack while req = 0 is ignored.
  - On ack: ir_write = 1 and pc_write = 1 (pc_src = 0) for that single cycle -> DECODE.
- DECODE: one cycle. Class latched from opcode:
  - 0110011 R -> alu_op 00.
  - 0010011 I -> alu_op 01.
  - 0000011 LOAD -> alu_op 10.
  - 0100011 STORE -> alu_op 10.
  - 1100011 BR -> alu_op 11.
  - Any other value -> TRAP with illegal_instr = 1.
- EXECUTE: one cycle. ALU_En = 0, alu_op = class. alu_src_imm = 1 for I, LOAD and STORE.
  - R or I -> WRITEBACK.
  - LOAD or STORE -> MEM.
  - BR: pc_write = branch_taken, pc_src = 1 -> FETCH.
- MEM: dmem_req = 1, dmem_we = (class == STORE). ALU_En = 0, alu_op = 10, alu_src_imm = 1, all held stable until dmem_ack.
  - On ack: LOAD -> WRITEBACK, STORE -> FETCH.
- WRITEBACK: reg_write = 1 for one cycle -> FETCH.
- Wait counter (8-bit):
  - Cleared on entry to FETCH and MEM; increments each cycle req is high and ack is low.
  - When it equals MAX_WAIT-1 with ack still low, the next state is TRAP with bus_error = 1.
  - Ack on that same cycle wins (no trap).
- TRAP: halted = 1 plus a sticky cause flag. All requests and writes are 0. Exits only via reset.
- Minimum latency with zero-wait ack (FETCH to next FETCH):
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BR: 3 cycles.

Optional Feature:
- Macro: PERF_COUNTER_EN.
- When defined, adds outputs cycle_cnt and instret_cnt (PERF_W bits each), both reset to 0:
  - cycle_cnt increments every cycle outside IDLE/TRAP.
  - instret_cnt increments on each exit to FETCH from EXECUTE (BR), MEM (STORE) or WRITEBACK.
  - Both wrap modulo 2^PERF_W and freeze in TRAP.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- R-type 0110011, zero-wait acks -> IDLE, FETCH, DECODE, EXECUTE (ALU_En=0, alu_op=00), WRITEBACK (reg_write=1), FETCH. 4 cycles per instruction.
- LOAD 0000011 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, alu_op=10 throughout, then reg_write pulse. STORE 0100011 -> dmem_we=1, no reg_write.
- BR 1100011: branch_taken=1 -> pc_write=1, pc_src=1 in EXECUTE. branch_taken=0 -> pc_write=0, back to FETCH.
- Opcode 1111111 -> TRAP, halted=1, illegal_instr=1. Held for 20 cycles despite acks; reset_n low then high -> IDLE, outputs cleared.
- MAX_WAIT=4, imem_ack never asserted -> TRAP after 4 request cycles, bus_error=1. Ack on the 4th cycle -> normal DECODE, no trap.
- reset_n asserted mid-MEM with dmem_req=1 -> dmem_req drops to 0 immediately (async). With PERF_COUNTER_EN, counters read 0 and instret_cnt=3 after three R-type instructions.
